hs_fifo_wr_arb: RTL and testbench

Packet-atomic round-robin arbiter that shares the write port of one `hs_fifo_afifo` instance between `NUM_REQ` valid/ready source streams in the source clock domain. A grant is held from the first beat of a packet until its `last` beat (or a fixed beat budget when last signalling is off). New grants are withheld while the FIFO reports almost-full. It is purely source-side logic and contains no clock-domain crossing.

---
 rtl/hs_fifo_arb_pkg.sv | 31 +++
 rtl/hs_fifo_rr_pick.sv | 35 +++
 rtl/hs_fifo_wr_arb.sv | 106 ++++++++++
 tb/tb_hs_fifo_wr_arb.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hs_fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Also holds a reference round-robin search function that other arbiters can reuse.
package hs_fifo_arb_pkg;

    localparam bit BOOL_TRUE  = 1'b1;
    localparam bit BOOL_FALSE = 1'b0;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Bits of req above the real requester count must be zero; a 32-wide scan
    // then wraps through them harmlessly.
    function automatic logic [4:0] rr_next(input logic [31:0] req, input logic [4:0] ptr);
        logic [4:0] idx;
        logic [4:0] cand;
        logic       found;
        idx   = ptr;
        found = 1'b0;
        for (int i = 0; i < 32; i++) begin
            cand = ptr + 5'(i);
            if (!found && req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/hs_fifo_rr_pick.sv
// Combinational masked priority encoder: first set bit of req at or after ptr,
// wrapping to the lowest set bit when nothing at or above ptr is set.
module hs_fifo_rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] hi_idx;
    logic [IW-1:0] lo_idx;
    logic          hi_found;

    // Descending scan so the last hit written is the lowest qualifying index.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_idx = IW'(i);
            end
            if (req[i] && (IW'(i) >= ptr)) begin
                hi_found = 1'b1;
                hi_idx   = IW'(i);
            end
        end
        idx = hi_found ? hi_idx : lo_idx;
        any = |req;
    end

endmodule

// File: rtl/hs_fifo_wr_arb.sv
// Packet-atomic round-robin arbiter sharing one FIFO write port between NUM_REQ streams.
// Grant is held until the last beat; the data path is a pure combinational mux.
module hs_fifo_wr_arb
    import hs_fifo_arb_pkg::*;
#(
    parameter type         DATA_TYPE      = logic,
    parameter int unsigned NUM_REQ        = 4,
    parameter bit          EN_LAST_SIGNAL = BOOL_FALSE,
    parameter int unsigned BURST_LEN      = 1,
    parameter bit          EN_AFULL_GATE  = BOOL_TRUE,
    localparam int         REQ_ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    srst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  DATA_TYPE                req_data [NUM_REQ],
    input  logic [NUM_REQ-1:0]      req_last,
    output logic                    wvalid,
    input  logic                    wready,
    output DATA_TYPE                wdata,
    output logic                    wlast,
    input  logic                    walmost_full,
    output logic [REQ_ID_WIDTH-1:0] grant_id,
    output logic                    busy
);

    localparam int CW = $clog2(BURST_LEN + 1);

    arb_state_e              state_q, state_d;
    logic [REQ_ID_WIDTH-1:0] ptr_q, ptr_d;
    logic [REQ_ID_WIDTH-1:0] grant_q, grant_d;
    logic [CW-1:0]           cnt_q, cnt_d;

    logic [REQ_ID_WIDTH-1:0] pick_idx;
    logic                    pick_any;

    hs_fifo_rr_pick #(
        .N  (NUM_REQ),
        .IW (REQ_ID_WIDTH)
    ) u_pick (
        .req (req_valid),
        .ptr (ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        cnt_d     = cnt_q;
        wvalid    = 1'b0;
        wdata     = '0;
        wlast     = 1'b0;
        req_ready = '0;
        case (state_q)
            ARB_IDLE: begin
                // almost-full only gates the start of a packet, never one in flight
                if (pick_any && !(EN_AFULL_GATE && walmost_full)) begin
                    grant_d = pick_idx;
                    cnt_d   = '0;
                    state_d = ARB_LOCKED;
                end
            end
            ARB_LOCKED: begin
                wvalid             = req_valid[grant_q];
                wdata              = req_data[grant_q];
                wlast              = EN_LAST_SIGNAL ? req_last[grant_q]
                                                    : (cnt_q == CW'(BURST_LEN - 1));
                req_ready[grant_q] = wready;
                if (wvalid && wready) begin
                    if (cnt_q != {CW{1'b1}}) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                    if (wlast) begin
                        state_d = ARB_IDLE;
                        ptr_d   = (grant_q == REQ_ID_WIDTH'(NUM_REQ - 1)) ? '0
                                                                          : grant_q + REQ_ID_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant_id = grant_q;
    assign busy     = (state_q == ARB_LOCKED);

endmodule

// File: tb/tb_hs_fifo_wr_arb.sv
// Bench for hs_fifo_wr_arb: two configurations (last-signalled, 4 requesters;
// fixed 4-beat bursts, 5 requesters, no gate) driven by shared random stimulus.
module tb_hs_fifo_wr_arb;
    import hs_fifo_arb_pkg::*;

    logic       clk = 1'b0;
    logic       srst;
    logic [4:0] rv;
    logic [4:0] rl;
    logic [7:0] rd [5];
    logic [7:0] rd0 [4];
    logic       wready;
    logic       afull;

    logic [3:0] rdy0;
    logic       wv0, wl0, busy0;
    logic [7:0] wd0;
    logic [1:0] gid0;

    logic [4:0] rdy1;
    logic       wv1, wl1, busy1;
    logic [7:0] wd1;
    logic [2:0] gid1;

    int checks = 0;
    int errors = 0;

    // Abstract model state: owner (-1 = nobody), beats sent in this packet, next start.
    int own [2] = '{-1, -1};
    int cnt [2] = '{0, 0};
    int ptr [2] = '{0, 0};

    logic [11:0] exp_q0 [$];
    logic [11:0] exp_q1 [$];

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 4; i++) rd0[i] = rd[i];
    end

    hs_fifo_wr_arb #(
        .DATA_TYPE      (logic [7:0]),
        .NUM_REQ        (4),
        .EN_LAST_SIGNAL (BOOL_TRUE),
        .BURST_LEN      (1),
        .EN_AFULL_GATE  (BOOL_TRUE)
    ) dut0 (
        .clk          (clk),
        .srst         (srst),
        .req_valid    (rv[3:0]),
        .req_ready    (rdy0),
        .req_data     (rd0),
        .req_last     (rl[3:0]),
        .wvalid       (wv0),
        .wready       (wready),
        .wdata        (wd0),
        .wlast        (wl0),
        .walmost_full (afull),
        .grant_id     (gid0),
        .busy         (busy0)
    );

    hs_fifo_wr_arb #(
        .DATA_TYPE      (logic [7:0]),
        .NUM_REQ        (5),
        .EN_LAST_SIGNAL (BOOL_FALSE),
        .BURST_LEN      (4),
        .EN_AFULL_GATE  (BOOL_FALSE)
    ) dut1 (
        .clk          (clk),
        .srst         (srst),
        .req_valid    (rv),
        .req_ready    (rdy1),
        .req_data     (rd),
        .req_last     (rl),
        .wvalid       (wv1),
        .wready       (wready),
        .wdata        (wd1),
        .wlast        (wl1),
        .walmost_full (afull),
        .grant_id     (gid1),
        .busy         (busy1)
    );

    // One cycle of the reference model for configuration k: predict the outputs
    // visible during this cycle, queue any predicted write beat, then advance.
    task automatic model_step(input int k);
        int         n, blen, cap, idx;
        bit         lmode, gate, found;
        logic [4:0] rdy_e;
        logic       wv_e, wl_e;
        logic [7:0] wd_e;
        logic [18:0] exp_v, act_v;
        n     = (k == 0) ? 4 : 5;
        blen  = (k == 0) ? 1 : 4;
        cap   = (k == 0) ? 1 : 7;
        lmode = (k == 0);
        gate  = (k == 0);
        rdy_e = '0;
        wv_e  = 1'b0;
        wl_e  = 1'b0;
        wd_e  = '0;
        if (own[k] >= 0) begin
            wv_e = rv[own[k]];
            wd_e = rd[own[k]];
            wl_e = lmode ? rl[own[k]] : (cnt[k] == blen - 1);
            rdy_e[own[k]] = wready;
        end
        exp_v = {own[k] >= 0, (own[k] >= 0) ? 3'(own[k]) : 3'd0, rdy_e, wv_e, wl_e, wd_e};
        if (k == 0) act_v = {busy0, busy0 ? {1'b0, gid0} : 3'd0, 1'b0, rdy0, wv0, wl0, wd0};
        else        act_v = {busy1, busy1 ? gid1 : 3'd0, rdy1, wv1, wl1, wd1};
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL ctl%0d t=%0t busy/gid/ready/wvalid/wlast/wdata got %h expected %h",
                     k, $time, act_v, exp_v);
        end
        if (wv_e && wready) begin
            if (k == 0) exp_q0.push_back({3'(own[k]), wl_e, wd_e});
            else        exp_q1.push_back({3'(own[k]), wl_e, wd_e});
        end
        if (srst) begin
            own[k] = -1;
            cnt[k] = 0;
            ptr[k] = 0;
        end else if (own[k] < 0) begin
            found = 1'b0;
            idx   = 0;
            for (int j = 0; j < n; j++) begin
                if (!found && rv[(ptr[k] + j) % n]) begin
                    found = 1'b1;
                    idx   = (ptr[k] + j) % n;
                end
            end
            if (found && !(gate && afull)) begin
                own[k] = idx;
                cnt[k] = 0;
            end
        end else if (wv_e && wready) begin
            if (cnt[k] < cap) cnt[k] = cnt[k] + 1;
            if (wl_e) begin
                ptr[k] = (own[k] + 1) % n;
                own[k] = -1;
            end
        end
    endtask

    always @(negedge clk) begin
        model_step(0);
        model_step(1);
    end

    // Monitor: every handshake the DUTs present must match the oldest predicted beat.
    always @(negedge clk) begin
        logic [11:0] e;
        #1;
        if (wv0 && wready) begin
            checks++;
            if (exp_q0.size() == 0) begin
                errors++;
                $display("FAIL beat0 t=%0t got %h expected none", $time, {1'b0, gid0, wl0, wd0});
            end else begin
                e = exp_q0.pop_front();
                if ({1'b0, gid0, wl0, wd0} !== e) begin
                    errors++;
                    $display("FAIL beat0 t=%0t got %h expected %h", $time, {1'b0, gid0, wl0, wd0}, e);
                end
            end
        end
        if (wv1 && wready) begin
            checks++;
            if (exp_q1.size() == 0) begin
                errors++;
                $display("FAIL beat1 t=%0t got %h expected none", $time, {gid1, wl1, wd1});
            end else begin
                e = exp_q1.pop_front();
                if ({gid1, wl1, wd1} !== e) begin
                    errors++;
                    $display("FAIL beat1 t=%0t got %h expected %h", $time, {gid1, wl1, wd1}, e);
                end
            end
        end
    end

    task automatic drive(input logic [4:0] v, input logic [4:0] l, input logic wr,
                         input logic af, input logic rst);
        @(posedge clk);
        #1;
        rv     = v;
        rl     = l;
        wready = wr;
        afull  = af;
        srst   = rst;
        for (int i = 0; i < 5; i++) rd[i] = 8'($urandom);
    endtask

    initial begin
        srst   = 1'b1;
        rv     = '0;
        rl     = '0;
        wready = 1'b0;
        afull  = 1'b0;
        for (int i = 0; i < 5; i++) rd[i] = '0;
        repeat (3) drive(5'h00, 5'h00, 1'b0, 1'b0, 1'b1);

        // every requester valid with single-beat packets: plain rotation
        repeat (24) drive(5'h1f, 5'h1f, 1'b1, 1'b0, 1'b0);
        repeat (12) drive(5'h00, 5'h00, 1'b1, 1'b0, 1'b0);

        // almost-full with only req0 asking, then released
        repeat (6) drive(5'h01, 5'h01, 1'b1, 1'b1, 1'b0);
        repeat (4) drive(5'h01, 5'h01, 1'b1, 1'b0, 1'b0);

        // multi-beat packets under wready pattern 1,0,0,1
        for (int c = 0; c < 40; c++) begin
            drive(5'h1f, ((c % 4) == 3) ? 5'h1f : 5'h00, ((c % 4) == 0) || ((c % 4) == 3),
                  1'b0, 1'b0);
        end

        // reset landing in the middle of packets
        repeat (3) drive(5'h1f, 5'h00, 1'b1, 1'b0, 1'b0);
        drive(5'h1f, 5'h00, 1'b1, 1'b0, 1'b1);
        repeat (8) drive(5'h1f, 5'h1f, 1'b1, 1'b0, 1'b0);

        for (int c = 0; c < 3000; c++) begin
            logic [4:0] v, l;
            for (int i = 0; i < 5; i++) begin
                v[i] = ($urandom_range(0, 3) != 0);
                l[i] = ($urandom_range(0, 2) == 0);
            end
            drive(v, l, $urandom_range(0, 2) != 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 199) == 0);
        end

        repeat (5) drive(5'h00, 5'h00, 1'b0, 1'b0, 1'b1);
        repeat (3) drive(5'h00, 5'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        checks++;
        if (exp_q0.size() != 0) begin
            errors++;
            $display("FAIL drain0 left %0d expected 0", exp_q0.size());
        end
        checks++;
        if (exp_q1.size() != 0) begin
            errors++;
            $display("FAIL drain1 left %0d expected 0", exp_q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
